// File: rtl/mips_cpu_pkg.sv
// Shared types for the HI/LO unit: op encoding and sequencer states.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_RSVD6 = 3'd6,
    OP_RSVD7 = 3'd7
  } hilo_op_t;

  typedef enum logic [1:0] {
    IDLE,
    DIV_LAUNCH,
    DIV_WAIT
  } hilo_state_t;

  // Codes 6 and 7 are reserved: they neither write nor stall.
  function automatic logic op_is_real(logic [2:0] op);
    return op <= 3'd5;
  endfunction

endpackage

// File: rtl/mips_cpu_mult.sv
// Combinational 32x32->64 multiplier; sign=1 treats both operands as signed.
module mips_cpu_mult (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sign,
  output logic [63:0] product
);

  logic signed [32:0] a_ext;
  logic signed [32:0] b_ext;
  logic signed [65:0] full;

  assign a_ext   = {sign & a[31], a};
  assign b_ext   = {sign & b[31], b};
  assign full    = a_ext * b_ext;
  assign product = full[63:0];

endmodule

// File: rtl/mips_cpu_hilo_unit.sv
// HI/LO register owner: single-cycle multiplies, MTHI/MTLO, and divide sequencing
// around an external divider with a watchdog.
module mips_cpu_hilo_unit
  import mips_cpu_pkg::*;
#(
  parameter int unsigned DIV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mf_req,
  input  logic        mf_sel,
  output logic [31:0] mf_data,
  output logic        stall,
  output logic        div_start,
  output logic        div_sign,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        div_done,
  input  logic        div_dbz,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_err
);

  localparam int unsigned CntW = $clog2(DIV_TIMEOUT + 1);

  hilo_state_t   state_q;
  logic [CntW-1:0] cnt_q;
  hilo_op_t      op_code;
  logic          op_req;
  logic [63:0]   product;

  assign op_code = hilo_op_t'(op);
  assign op_req  = op_valid & op_is_real(op);

  mips_cpu_mult u_mult (
    .a       (rs_data),
    .b       (rt_data),
    .sign    (op_code == OP_MULT),
    .product (product)
  );

  // Only a divide in flight holds off requests; idle-bus cycles never stall.
  assign stall   = (state_q != IDLE) && (op_req || mf_req);
  assign mf_data = mf_sel ? hi : lo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hi           <= '0;
      lo           <= '0;
      div_start    <= 1'b0;
      div_sign     <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      div_err      <= 1'b0;
    end else begin
      div_start <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (op_req) begin
            unique case (op_code)
              OP_MULT, OP_MULTU: {hi, lo} <= product;
              OP_MTHI:           hi <= rs_data;
              OP_MTLO:           lo <= rs_data;
              OP_DIV, OP_DIVU: begin
                div_dividend <= rs_data;
                div_divisor  <= rt_data;
                div_sign     <= (op_code == OP_DIV);
                div_start    <= 1'b1;
                state_q      <= DIV_LAUNCH;
              end
              default: ;
            endcase
          end
        end
        DIV_LAUNCH: begin
          cnt_q   <= '0;
          state_q <= DIV_WAIT;
        end
        DIV_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (div_done) begin
            if (div_dbz) begin
              div_err <= 1'b1;
            end else begin
              hi <= div_remainder;
              lo <= div_quotient;
            end
            state_q <= IDLE;
          end else if (cnt_q == CntW'(DIV_TIMEOUT - 1)) begin
            div_err <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mips_cpu_hilo_unit.md
Name: mips_cpu_hilo_unit

Overview:
- Owns the architectural HI/LO registers and sequences every HI/LO-writing instruction: MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits directly upstream and downstream of the signed/unsigned divider wrapper (mips_cpu_div):
  - launches the divider with registered operands and the sign select;
  - waits for its done pulse;
  - commits the remainder to HI and the quotient to LO.
- Stalls the pipeline on MFHI/MFLO and on new HI/LO ops while a divide is in flight.

Parameters:
- DIV_TIMEOUT, 64, maximum number of cycles spent in DIV_WAIT before the watchdog aborts the divide and raises div_err.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- op_valid  input  1  HI/LO op presented this cycle; the caller holds it until stall=0
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6 and 7 are ignored (no write, no stall)
- rs_data  input  32  dividend / multiplicand / MTxx source
- rt_data  input  32  divisor / multiplier
- mf_req  input  1  MFHI/MFLO read request
- mf_sel  input  1  0=LO, 1=HI
- mf_data  output  32  selected HI/LO value (combinational from the registers)
- stall  output  1  request or op not accepted this cycle
- div_start  output  1  one-cycle launch pulse to the divider
- div_sign  output  1  1=DIV, 0=DIVU; held for the whole divide
- div_dividend  output  32  registered operand; held for the whole divide
- div_divisor  output  32  registered operand; held for the whole divide
- div_quotient  input  32  from the divider
- div_remainder  input  32  from the divider
- div_done  input  1  divider result valid
- div_dbz  input  1  divide-by-zero, qualified by div_done
- hi  output  32  HI register
- lo  output  32  LO register
- div_err  output  1  sticky flag: watchdog expired or divide by zero

Behaviour:
- Reset (reset=0, asynchronous):
  - hi=0, lo=0, state=IDLE, div_start=0, div_sign=0, div_dividend=0, div_divisor=0, timeout counter=0, div_err=0.
  - A reset during DIV_WAIT abandons the divide. The divider instance shares the same reset.
- States: IDLE, DIV_LAUNCH, DIV_WAIT.
- IDLE, stall=0. Ops are accepted at the clock edge:
  - MULT: {hi,lo} <= signed 64-bit product of rs_data and rt_data. Single cycle; the new values are visible the next cycle.
  - MULTU: same as MULT, with an unsigned product.
  - MTHI: hi <= rs_data. lo is unchanged.
  - MTLO: lo <= rs_data. hi is unchanged.
  - DIV/DIVU:
    - capture rs_data into div_dividend and rt_data into div_divisor;
    - div_sign <= (op==DIV);
    - go to DIV_LAUNCH.
- DIV_LAUNCH:
  - div_start=1 for exactly this cycle; stall=1.
  - Next state is DIV_WAIT; the counter is cleared.
- DIV_WAIT:
  - stall=1 whenever op_valid or mf_req is asserted. The counter increments every cycle.
  - On div_done=1 with div_dbz=0: hi <= div_remainder, lo <= div_quotient, next state IDLE.
  - On div_done=1 with div_dbz=1: hi and lo are unchanged, div_err <= 1, next state IDLE.
  - When the counter reaches DIV_TIMEOUT without div_done: div_err <= 1, hi and lo are unchanged, next state IDLE.
  - stall is still 1 in the div_done cycle. The result is readable in the following cycle (no same-cycle forwarding).
- Idle cycles: stall=0 whenever no op_valid and no mf_req are present, in any state.
- mf_data = mf_sel ? hi : lo at all times. It is meaningful only when stall=0.
- Simultaneous op_valid and mf_req in IDLE:
  - both are accepted;
  - mf_data returns the pre-write value;
  - the write lands at the edge.
- div_done while in IDLE or DIV_LAUNCH is ignored.
- div_err clears only on reset.

Decomposition:
- Shared package mips_cpu_pkg holds:
  - typedef hilo_op_t, an enum of the 3-bit op codes;
  - typedef hilo_state_t: IDLE, DIV_LAUNCH, DIV_WAIT.
- Sub-module mips_cpu_mult: combinational 32x32→64 multiplier with a sign input, kept separate so it can later be pipelined. The divider is instantiated by the parent, not inside this block.

Test Plan:
- DIV, rs=0xFFFFFFF9 (-7), rt=2 → div_start pulses one cycle with div_sign=1. After the done pulse: lo=0xFFFFFFFD, hi=0xFFFFFFFF, stall drops the cycle after div_done.
- DIVU, rs=100, rt=7 → lo=14, hi=2.
- MFLO issued the cycle after DIV acceptance → stall stays 1 until the cycle after div_done; mf_data then equals the quotient.
- MULT, rs=0xFFFFFFFD (-3), rt=5 → next cycle hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU with the same operands → hi=0x00000004, lo=0xFFFFFFF1.
- DIV with rt=0, divider returns div_done=1, div_dbz=1, with hi=0x11111111 and lo=0x22222222 preloaded via MTHI/MTLO → hi and lo are unchanged, div_err=1.
- Reset mid-divide, and separately a divider that never asserts done:
  - reset=0 in DIV_WAIT → immediately hi=0, lo=0, stall=0, state IDLE;
  - no done for DIV_TIMEOUT=64 cycles → div_err=1, return to IDLE.
